// File: rtl/vdp_bus_pkg.sv
`default_nettype none
// ============================================================================
// vdp_bus_pkg : shared types and constants for the VDP CPU-port bus master
// Revision    : 1.0
// ============================================================================
package vdp_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } bus_state_t;

  localparam logic [1:0] VDP_PORT_VRAM = 2'd0;
  localparam logic [1:0] VDP_PORT_CTRL = 2'd1;
  localparam logic [1:0] VDP_PORT_PAL  = 2'd2;
  localparam logic [1:0] VDP_PORT_IREG = 2'd3;

  typedef struct packed {
    logic       wr;
    logic [1:0] port;
    logic [7:0] data;
  } vdp_req_t;

  // Down-counter load value for a phase lasting the given number of clocks.
  function automatic logic [3:0] cyc_load(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_bus_master_if.sv
`default_nettype none
// ============================================================================
// vdp_bus_master_if : VDP CPU I/O port signals (initiator = master)
// Revision          : 1.0
// ============================================================================
interface vdp_bus_master_if;

  logic [1:0] mode;
  logic       csw_n;
  logic       csr_n;
  logic [7:0] cdo;
  logic [7:0] cdi;

  modport master (
    output mode,
    output csw_n,
    output csr_n,
    output cdo,
    input  cdi
  );

  modport slave (
    input  mode,
    input  csw_n,
    input  csr_n,
    input  cdo,
    output cdi
  );

endinterface
`default_nettype wire

// File: rtl/vdp_req_fifo.sv
`default_nettype none
// ============================================================================
// vdp_req_fifo : first-word-fall-through request FIFO with full/empty/count
// Revision     : 1.0
// ============================================================================
module vdp_req_fifo
  import vdp_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  vdp_req_t                 data_i,
  input  logic                     pop_i,
  output vdp_req_t                 head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  vdp_req_t          mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              push_w;
  logic              pop_w;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_w = push_i & ~full_o;
  assign pop_w  = pop_i & ~empty_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_w)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_w, pop_w})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/vdp_bus_master.sv
`default_nettype none
// ============================================================================
// vdp_bus_master : queues host port reads/writes and plays them out as timed
//                  single-strobe cycles on the VDP CPU I/O port
// Revision       : 1.0
// ============================================================================
module vdp_bus_master
  import vdp_bus_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 8,
  parameter int RECOVER_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wr_i,
  input  logic [1:0]        req_port_i,
  input  logic [7:0]        req_data_i,
  output logic              rsp_valid_o,
  output logic [7:0]        rsp_data_o,
  output logic              busy_o,
  vdp_bus_master_if.master  bus,
  input  logic              int_n_i,
  output logic              irq_o
);

  localparam logic [1:0] ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] ST_SETUP   = 2'(SETUP);
  localparam logic [1:0] ST_STROBE  = 2'(STROBE);
  localparam logic [1:0] ST_RECOVER = 2'(RECOVER);

  localparam logic [3:0] SETUP_LOAD   = cyc_load(SETUP_CYC);
  localparam logic [3:0] STROBE_LOAD  = cyc_load(STROBE_CYC);
  localparam logic [3:0] RECOVER_LOAD = cyc_load(RECOVER_CYC);

  vdp_req_t                      req_w;
  vdp_req_t                      head_w;
  logic                          full_w;
  logic                          empty_w;
  logic                          pop_w;
  logic [$clog2(FIFO_DEPTH):0]   count_w;

  logic [1:0] state_q,     state_d;
  logic [3:0] cnt_q,       cnt_d;
  logic [1:0] mode_q,      mode_d;
  logic [7:0] cdo_q,       cdo_d;
  logic       csw_n_q,     csw_n_d;
  logic       csr_n_q,     csr_n_d;
  logic       rd_q,        rd_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q,  rsp_data_d;
  logic [1:0] irq_sync_q;

  assign req_w = '{wr: req_wr_i, port: req_port_i, data: req_data_i};
  assign pop_w = (state_q == ST_IDLE) & ~empty_w;

  vdp_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid_i),
    .data_i  (req_w),
    .pop_i   (pop_w),
    .head_o  (head_w),
    .full_o  (full_w),
    .empty_o (empty_w),
    .count_o (count_w)
  );

  assign req_ready_o = ~full_w;
  assign busy_o      = (count_w != '0) | (state_q != ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign irq_o       = irq_sync_q[1];

  assign bus.mode  = mode_q;
  assign bus.cdo   = cdo_q;
  assign bus.csw_n = csw_n_q;
  assign bus.csr_n = csr_n_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    cdo_d       = cdo_q;
    csw_n_d     = csw_n_q;
    csr_n_d     = csr_n_q;
    rd_d        = rd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (!empty_w) begin
          mode_d  = head_w.port;
          cdo_d   = head_w.wr ? head_w.data : 8'h00;
          rd_d    = ~head_w.wr;
          cnt_d   = SETUP_LOAD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          csw_n_d = rd_q;
          csr_n_d = ~rd_q;
          cnt_d   = STROBE_LOAD;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          // Last low clock: the responder's data is settled, capture it here.
          if (rd_q) begin
            rsp_data_d  = bus.cdi;
            rsp_valid_d = 1'b1;
          end
          csw_n_d = 1'b1;
          csr_n_d = 1'b1;
          cnt_d   = RECOVER_LOAD;
          state_d = ST_RECOVER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      mode_q      <= 2'd0;
      cdo_q       <= 8'h00;
      csw_n_q     <= 1'b1;
      csr_n_q     <= 1'b1;
      rd_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      cdo_q       <= cdo_d;
      csw_n_q     <= csw_n_d;
      csr_n_q     <= csr_n_d;
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_sync_q <= 2'b00;
    end else begin
      irq_sync_q <= {irq_sync_q[0], ~int_n_i};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vdp_bus_master.sv
`default_nettype none
// ============================================================================
// tb_vdp_bus_master : directed + randomized bench with a transaction-level
//                     reference model of the VDP port initiator
// Revision          : 1.0
// ============================================================================
module tb_vdp_bus_master;

  localparam int SETUP_CYC   = 2;
  localparam int STROBE_CYC  = 8;
  localparam int RECOVER_CYC = 3;
  localparam int PERIOD      = 1 + SETUP_CYC + STROBE_CYC + RECOVER_CYC;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [1:0] req_port;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       int_n;
  logic       irq;

  vdp_bus_master_if bus ();

  vdp_bus_master #(
    .FIFO_DEPTH  (4),
    .SETUP_CYC   (SETUP_CYC),
    .STROBE_CYC  (STROBE_CYC),
    .RECOVER_CYC (RECOVER_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wr_i    (req_wr),
    .req_port_i  (req_port),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy),
    .bus         (bus),
    .int_n_i     (int_n),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    logic [1:0] mode;
    logic [7:0] cdo;
    int         setup;
    int         gap;
    int         low;
    int         fall_cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    int         nfalls;
    int         cyc;
  } rsp_t;

  typedef struct {
    bit         wr;
    logic [1:0] port;
    logic [7:0] cdo;
  } exp_t;

  int compared   = 0;
  int mismatched = 0;

  ev_t        ev_q[$];
  rsp_t       rsp_q[$];
  exp_t       exp_q[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rd_vals[$];
  int         ev_base  = 0;
  int         rsp_base = 0;
  int         first_stall;

  // Bus monitor: turns strobe activity into a transaction log.
  int         cyc = 0, stab = 0, hi_cnt = 0, low_cnt = 0, nfalls = 0;
  int         both_low = 0, unstable = 0, double_rsp = 0;
  bit         prev_hi = 1'b1, prev_rsp = 1'b0;
  logic [9:0] cur_val, prev_val = '0, lock_val = '0;
  ev_t        mon_e;
  rsp_t       mon_r;

  always @(negedge clk) begin
    cyc++;
    cur_val = {bus.mode, bus.cdo};
    if (cur_val == prev_val) stab++; else stab = 0;
    prev_val = cur_val;
    if (!bus.csw_n && !bus.csr_n) both_low++;
    if (prev_hi && !(bus.csw_n && bus.csr_n)) begin
      mon_e.wr = !bus.csw_n; mon_e.mode = bus.mode; mon_e.cdo = bus.cdo;
      mon_e.setup = stab; mon_e.gap = hi_cnt; mon_e.low = 0; mon_e.fall_cyc = cyc;
      ev_q.push_back(mon_e);
      nfalls++; low_cnt = 1; lock_val = cur_val; prev_hi = 1'b0;
    end else if (!prev_hi && !(bus.csw_n && bus.csr_n)) begin
      low_cnt++;
      if (cur_val != lock_val) unstable++;
    end else if (!prev_hi) begin
      ev_q[ev_q.size()-1].low = low_cnt;
      hi_cnt = 1; prev_hi = 1'b1;
    end else begin
      hi_cnt++;
    end
    if (rsp_valid === 1'b1) begin
      mon_r.data = rsp_data; mon_r.nfalls = nfalls; mon_r.cyc = cyc;
      rsp_q.push_back(mon_r);
      if (prev_rsp) double_rsp++;
    end
    prev_rsp = (rsp_valid === 1'b1);
  end

  // Responder: read data becomes valid from the 4th low clock of csr_n.
  int rlow = 0, rd_idx = 0;
  always @(negedge clk) begin
    if (bus.csr_n === 1'b0) begin
      rlow++;
      bus.cdi = (rlow >= 4 && rd_idx < rd_vals.size()) ? rd_vals[rd_idx] : 8'hEE;
    end else begin
      if (rlow > 0) rd_idx++;
      rlow = 0;
      bus.cdi = 8'hEE;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Must be entered just after a falling clock edge.
  task automatic push(input bit wr, input logic [1:0] port, input logic [7:0] d,
                      input logic [7:0] rv, input int idx);
    int   t;
    exp_t e;
    t = 0;
    req_valid = 1'b1; req_wr = wr; req_port = port; req_data = d;
    if (!req_ready && first_stall < 0) first_stall = idx;
    while (!req_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("push/ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    e.wr = wr; e.port = port; e.cdo = wr ? d : 8'h00;
    exp_q.push_back(e);
    if (!wr) begin
      rd_vals.push_back(rv);
      exp_rd.push_back(rv);
    end
  endtask

  task automatic drain_and_check(input string tag, input bit burst);
    int   t;
    int   ei;
    ev_t  e;
    rsp_t r;
    t = 0;
    repeat (2) @(negedge clk);
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "/drained"}, (t < 3000), 1);
    repeat (3) @(negedge clk);
    chk({tag, "/nstrobes"}, ev_q.size() - ev_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (ev_base + i < ev_q.size()) begin
        e = ev_q[ev_base + i];
        chk({tag, "/wr"},   e.wr,   exp_q[i].wr);
        chk({tag, "/mode"}, e.mode, exp_q[i].port);
        chk({tag, "/cdo"},  e.cdo,  exp_q[i].cdo);
        chk({tag, "/low"},  e.low,  STROBE_CYC);
        chk({tag, "/setup_ok"}, (e.setup >= SETUP_CYC), 1);
        chk({tag, "/gap_ok"},   (e.gap >= RECOVER_CYC), 1);
        if (burst && i > 0)
          chk({tag, "/period"}, e.fall_cyc - ev_q[ev_base + i - 1].fall_cyc, PERIOD);
      end
    end
    chk({tag, "/nrsp"}, rsp_q.size() - rsp_base, exp_rd.size());
    for (int j = 0; j < exp_rd.size(); j++) begin
      if (rsp_base + j < rsp_q.size()) begin
        r = rsp_q[rsp_base + j];
        chk({tag, "/rsp_data"}, r.data, exp_rd[j]);
        ei = r.nfalls - 1;
        if (ei >= 0 && ei < ev_q.size()) begin
          chk({tag, "/rsp_after_read"}, ev_q[ei].wr, 0);
          chk({tag, "/rsp_latency"}, r.cyc - ev_q[ei].fall_cyc, STROBE_CYC);
        end
      end
    end
    chk({tag, "/both_low"},   both_low,   0);
    chk({tag, "/unstable"},   unstable,   0);
    chk({tag, "/double_rsp"}, double_rsp, 0);
    ev_base  = ev_q.size();
    rsp_base = rsp_q.size();
    exp_q.delete();
    exp_rd.delete();
  endtask

  int         s, rb, t;
  bit         rwr;
  logic       h[$];
  logic       nv;
  logic [7:0] rlist [8];

  initial begin
    rst = 1'b0; int_n = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
    req_port = 2'd0; req_data = 8'h00; bus.cdi = 8'hEE;
    first_stall = -1;

    // Reset state
    #2 rst = 1'b1;
    #2;
    chk("rst/csw_n", bus.csw_n, 1);
    chk("rst/csr_n", bus.csr_n, 1);
    chk("rst/mode", bus.mode, 0);
    chk("rst/cdo", bus.cdo, 0);
    chk("rst/rsp_valid", rsp_valid, 0);
    chk("rst/rsp_data", rsp_data, 0);
    chk("rst/irq", irq, 0);
    chk("rst/busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst/req_ready", req_ready, 1);

    // Single write
    s = ev_q.size();
    push(1'b1, 2'd1, 8'h87, 8'h00, -1);
    drain_and_check("wr1", 1'b0);
    if (ev_q.size() > s) chk("wr1/setup_exact", ev_q[s].setup, SETUP_CYC);

    // Single read
    s = ev_q.size();
    push(1'b0, 2'd0, 8'h33, 8'h5A, -1);
    drain_and_check("rd1", 1'b0);
    chk("rd1/held", rsp_data, 8'h5A);

    // Burst of six writes into the 4-deep FIFO
    first_stall = -1;
    for (int i = 0; i < 6; i++)
      push(1'b1, 2'(i), 8'(8'h10 + i), 8'h00, i);
    chk("burst/stall_at", first_stall, 5);
    drain_and_check("burst", 1'b1);

    // Mixed order: W W R W
    s = ev_q.size(); rb = rsp_q.size();
    push(1'b1, 2'd1, 8'h00, 8'h00, -1);
    push(1'b1, 2'd1, 8'h40, 8'h00, -1);
    push(1'b0, 2'd0, 8'hFF, 8'hC3, -1);
    push(1'b1, 2'd0, 8'h11, 8'h00, -1);
    drain_and_check("mixed", 1'b0);
    if (rsp_q.size() > rb) chk("mixed/rsp_pos", rsp_q[rb].nfalls - s, 3);

    // Reset during the 4th low clock of a write with two entries queued
    s = ev_q.size(); rb = rsp_q.size();
    push(1'b1, 2'd1, 8'hA5, 8'h00, -1);
    push(1'b1, 2'd2, 8'h3C, 8'h00, -1);
    push(1'b1, 2'd3, 8'h96, 8'h00, -1);
    t = 0;
    while (bus.csw_n !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rstmid/strobe_seen", bus.csw_n, 0);
    repeat (3) @(negedge clk);
    chk("rstmid/pre_csw_n", bus.csw_n, 0);
    #1 rst = 1'b1;
    #1;
    chk("rstmid/csw_n", bus.csw_n, 1);
    chk("rstmid/busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (40) @(negedge clk);
    chk("rstmid/no_more_strobes", ev_q.size() - s, 1);
    chk("rstmid/no_rsp", rsp_q.size() - rb, 0);
    chk("rstmid/idle", busy, 0);
    ev_base = ev_q.size(); rsp_base = rsp_q.size();
    push(1'b1, 2'd2, 8'h5C, 8'h00, -1);
    drain_and_check("after_rst", 1'b0);

    // Randomized requests with random idle gaps
    for (int i = 0; i < 8; i++) rlist[i] = 8'($urandom);
    for (int i = 0; i < 14; i++) begin
      rwr = 1'($urandom);
      push(rwr, 2'($urandom), 8'($urandom), rlist[i % 8], -1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    drain_and_check("rand", 1'b0);

    // Interrupt: directed 5-clock pulse, then random toggling, vs a 2-clock delay model
    h.push_back(1'b1);
    h.push_back(1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("irq", irq, !h[h.size()-2]);
      if (k < 5)       nv = 1'b0;
      else if (k < 12) nv = 1'b1;
      else if (k < 34) nv = 1'($urandom);
      else             nv = 1'b1;
      int_n = nv;
      h.push_back(nv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vdp_bus_master.md
Name: vdp_bus_master

Overview:
- Initiator side of the VDP CPU I/O port protocol: {mode[1:0], csw_n, csr_n, cdo[7:0]} out, cdi[7:0] back.
- Lets an on-FPGA host (soft Z80 glue, test sequencer, boot loader) queue VDP port reads and writes.
- Each request becomes one strobe cycle, timed so the responder's latch-and-compare detector sees exactly one request per strobe.
- Returns read data and a synchronised interrupt.

Parameters:
- FIFO_DEPTH, 4: request FIFO entries; power of two, 2..16.
- SETUP_CYC, 2: clocks mode/cdo are stable before the strobe falls; 1..15.
- STROBE_CYC, 8: clocks the strobe is held low; 2..15. Read data is sampled on the last low clock.
- RECOVER_CYC, 3: clocks both strobes are high before the next setup; 2..15.

Ports:
- clk  in  1  system clock, same domain as the VDP.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  host request present.
- req_ready  out  1  FIFO not full; a transfer occurs when req_valid & req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_port  in  2  VDP port 0..3.
- req_data  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-clock pulse carrying read data.
- rsp_data  out  8  read data; held until the next read completes.
- busy  out  1  FIFO not empty or FSM not IDLE.
- mode  out  2  port select to the VDP.
- csw_n  out  1  write strobe, active low.
- csr_n  out  1  read strobe, active low.
- cdo  out  8  write data to the VDP.
- cdi  in  8  read data from the VDP.
- int_n  in  1  VDP interrupt, active low.
- irq  out  1  int_n inverted through a 2-flop synchroniser.

Behaviour:
- Reset (asynchronous, active-high):
  - csw_n = csr_n = 1; mode = 0; cdo = 0; rsp_valid = 0; rsp_data = 0; irq = 0.
  - FIFO emptied; FSM in IDLE; req_ready = 1 after reset deasserts.
- Output registration: all outputs to the VDP come from flops. The two strobes are never low together.
- FIFO (first-word-fall-through, entries {wr, port, data}):
  - Simultaneous push and pop when full is not allowed; req_ready is 0 when full.
  - Simultaneous push and pop when 1 ≤ count < FIFO_DEPTH keeps count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, STROBE, RECOVER. A single 4-bit down-counter serves all timed states.
  - IDLE: if the FIFO is not empty, pop the head, latch mode/cdo (cdo = 0 for reads), load the counter with SETUP_CYC-1, go to SETUP.
  - SETUP: strobes high. When the counter reaches 0, drive csw_n = 0 (write) or csr_n = 0 (read), load STROBE_CYC-1, go to STROBE.
  - STROBE: strobe held low; mode and cdo stay stable. When the counter reaches 0:
    - read: rsp_data <= cdi, pulse rsp_valid on the next clock;
    - both: strobes return high, load RECOVER_CYC-1, go to RECOVER.
  - RECOVER: when the counter reaches 0, go to IDLE. No IDLE bubble is needed beyond that one clock.
- Timing per request: minimum period = 1 + SETUP_CYC + STROBE_CYC + RECOVER_CYC clocks; 14 with defaults.
  - Write: csw_n low for exactly STROBE_CYC clocks.
  - Read: rsp_valid pulses SETUP_CYC + STROBE_CYC + 1 clocks after the pop (11 with defaults).
- Back-to-back requests: RECOVER_CYC ≥ 2 guarantees the responder sees the strobe pair return to {1,1} before the next strobe.
- Order: reads and writes complete strictly in FIFO order.
- Reset mid-operation: strobes go high immediately. The in-flight request and queued entries are dropped and no rsp_valid is issued.
- irq lags int_n by 2 clocks; it is never gated by the FSM.

Decomposition:
- Package vdp_bus_pkg holds:
  - state enum bus_state_t {IDLE, SETUP, STROBE, RECOVER};
  - port constants VDP_PORT_VRAM = 0, VDP_PORT_CTRL = 1, VDP_PORT_PAL = 2, VDP_PORT_IREG = 3;
  - request struct vdp_req_t {wr, port[1:0], data[7:0]}.
- One sub-module, vdp_req_fifo: parameterised FWFT FIFO of vdp_req_t with full/empty/count. The FSM and synchroniser stay in the top.

Test Plan:
- Single write: port 1, data 0x87 with defaults → mode = 1 and cdo = 0x87 two clocks before csw_n falls; csw_n low exactly 8 clocks; csr_n stays 1; rsp_valid never pulses.
- Single read: port 0, cdi model returns 0x5A from strobe +3 → csr_n low 8 clocks; rsp_valid pulses once, 11 clocks after the pop, with rsp_data = 0x5A.
- Burst: 6 writes pushed back-to-back into a 4-deep FIFO → req_ready drops after 4 entries (5 if one is popped); all 6 strobes are emitted in order; each high gap ≥ 3 clocks; the responder model counts exactly 6 CpuReq.
- Mixed order: W(1, 0x00), W(1, 0x40), R(0), W(0, 0x11) → strobe sequence csw, csw, csr, csw; exactly one rsp_valid, between the 3rd and 4th strobes.
- Reset mid-strobe: assert reset during the 4th low clock of a write with 2 entries queued → csw_n = 1 asynchronously; busy = 0; no further strobes after release until a new push.
- Interrupt: int_n driven low for 5 clocks → irq high 5 clocks, starting 2 clocks after int_n falls.
